// File: rtl/reg_share_pkg.sv
// Shared types and helpers for the shared-register round-robin arbiter.
package reg_share_pkg;

   // Arbiter control states.
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_OWN  = 1'b1
   } state_t;

   // Largest requester count the search helper supports, and its index width.
   localparam int MAX_NREQ  = 32;
   localparam int MAX_IDX_W = 5;
   localparam int CNT_W     = MAX_IDX_W + 1;
   localparam int PICK_W    = MAX_IDX_W + 1;

   // Width of an index able to address n items (never narrower than one bit).
   function automatic int idx_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // Index width for the default four-requester configuration.
   localparam int IDX_W_DEF = idx_width(4);

   // Round-robin search: first asserted request at or after last+1, modulo n.
   // Returns {found, index}. Bits of req at or above n are ignored.
   function automatic logic [PICK_W-1:0] rr_pick(
      input logic [MAX_NREQ-1:0]  req,
      input logic [MAX_IDX_W-1:0] last,
      input logic [CNT_W-1:0]     n
   );
      logic                 found;
      logic [MAX_IDX_W-1:0] idx;
      logic [CNT_W-1:0]     j;
      found = 1'b0;
      idx   = '0;
      for (int off = 1; off <= MAX_NREQ; off++) begin
         j = {1'b0, last} + CNT_W'(off);
         if (j >= n) begin
            j = j - n;
         end
         if (!found && (CNT_W'(off) <= n) && req[j[MAX_IDX_W-1:0]]) begin
            found = 1'b1;
            idx   = j[MAX_IDX_W-1:0];
         end
      end
      return {found, idx};
   endfunction

endpackage

// File: rtl/rr_pick_next.sv
// Combinational round-robin selector: next requester after the last owner.
module rr_pick_next
   import reg_share_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int IDX_W = 2
) (
   input  logic [NREQ-1:0]  req,
   input  logic [IDX_W-1:0] last,
   output logic             valid,
   output logic [IDX_W-1:0] idx
);

   logic [MAX_NREQ-1:0] req_wide;
   logic [PICK_W-1:0]   pick;

   // Widen the request vector to the helper's fixed width, unused slots idle.
   generate
      for (genvar gi = 0; gi < MAX_NREQ; gi++) begin : g_widen
         if (gi < NREQ) begin : g_used
            assign req_wide[gi] = req[gi];
         end else begin : g_unused
            assign req_wide[gi] = 1'b0;
         end
      end
   endgenerate

   // Search starting just past the last owner.
   always_comb begin
      pick  = rr_pick(req_wide, MAX_IDX_W'(last), CNT_W'(NREQ));
      valid = pick[PICK_W-1];
      idx   = IDX_W'(pick[MAX_IDX_W-1:0]);
   end

endmodule

// File: rtl/reg_share_arb.sv
// Round-robin arbiter owning a single shared W-bit register; one requester
// at a time writes it, either once or for a locked burst of up to MAX_HOLD.
module reg_share_arb
   import reg_share_pkg::*;
#(
   parameter int NREQ     = 4,
   parameter int W        = 8,
   parameter int MAX_HOLD = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ-1:0]          lock,
   input  logic [NREQ*W-1:0]        d,
   output logic [NREQ-1:0]          gnt,
   output logic                     ack,
   output logic [W-1:0]             q,
   output logic [$clog2(NREQ)-1:0]  owner,
   output logic                     busy
);

   localparam int IDX_W  = idx_width(NREQ);
   localparam int HOLD_W = idx_width(MAX_HOLD);

   state_t             state_reg;
   logic [NREQ-1:0]    gnt_reg;
   logic               ack_reg;
   logic [W-1:0]       q_reg;
   logic [IDX_W-1:0]   owner_reg;
   logic [IDX_W-1:0]   last_reg;
   logic [HOLD_W-1:0]  hold_cnt_reg;

   logic               pick_valid;
   logic [IDX_W-1:0]   pick_idx;
   logic [NREQ-1:0]    gnt_next;
   logic [W-1:0]       d_arr [NREQ];
   logic               owner_req;
   logic               owner_lock;
   logic               hold_last;

   // Unpack the flat data bus into one word per requester.
   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
         assign d_arr[gi]    = d[gi*W +: W];
         assign gnt_next[gi] = (pick_idx == IDX_W'(gi));
      end
   endgenerate

   rr_pick_next #(
      .NREQ  (NREQ),
      .IDX_W (IDX_W)
   ) u_pick (
      .req   (req),
      .last  (last_reg),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   // Owner-side request, lock and burst-limit qualifiers.
   always_comb begin
      owner_req  = req[owner_reg];
      owner_lock = lock[owner_reg];
      hold_last  = (hold_cnt_reg == HOLD_W'(MAX_HOLD - 1));
   end

   // Arbitration FSM, shared register and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= ST_IDLE;
         gnt_reg      <= '0;
         ack_reg      <= 1'b0;
         q_reg        <= '0;
         owner_reg    <= '0;
         last_reg     <= IDX_W'(NREQ - 1);
         hold_cnt_reg <= '0;
      end else begin
         ack_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (pick_valid) begin
                  gnt_reg      <= gnt_next;
                  owner_reg    <= pick_idx;
                  last_reg     <= pick_idx;
                  hold_cnt_reg <= '0;
                  state_reg    <= ST_OWN;
               end
            end
            ST_OWN: begin
               if (owner_req) begin
                  q_reg        <= d_arr[owner_reg];
                  ack_reg      <= 1'b1;
                  hold_cnt_reg <= hold_cnt_reg + HOLD_W'(1);
                  if (!owner_lock || hold_last) begin
                     gnt_reg   <= '0;
                     state_reg <= ST_IDLE;
                  end
               end else begin
                  // Owner withdrew: release without writing.
                  gnt_reg   <= '0;
                  state_reg <= ST_IDLE;
               end
            end
            default: begin
               gnt_reg   <= '0;
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign gnt   = gnt_reg;
   assign ack   = ack_reg;
   assign q     = q_reg;
   assign owner = owner_reg;
   assign busy  = (state_reg == ST_OWN);

endmodule

// File: tb/tb_reg_share_arb.sv
// Directed bench for reg_share_arb with hand-computed expected values.
module tb_reg_share_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [3:0]  lock;
   logic [31:0] d;
   logic [3:0]  gnt;
   logic        ack;
   logic [7:0]  q;
   logic [1:0]  owner;
   logic        busy;

   int n_vec = 0;
   int n_bad = 0;

   reg_share_arb #(
      .NREQ     (4),
      .W        (8),
      .MAX_HOLD (4)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .lock  (lock),
      .d     (d),
      .gnt   (gnt),
      .ack   (ack),
      .q     (q),
      .owner (owner),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end else begin
         $display("ok   %s: %0h", tag, obs);
      end
   endtask

   // Advance one clock and settle just past the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Check the full output set in one line-per-field sweep.
   task automatic check_all(input string tag, input logic [3:0] e_gnt, input logic e_ack,
                            input logic [7:0] e_q, input logic e_busy);
      check_val({tag, ".gnt"},  32'(gnt),  32'(e_gnt));
      check_val({tag, ".ack"},  32'(ack),  32'(e_ack));
      check_val({tag, ".q"},    32'(q),    32'(e_q));
      check_val({tag, ".busy"}, 32'(busy), 32'(e_busy));
   endtask

   initial begin
      rst  = 1'b1;
      req  = 4'b1111;
      lock = 4'b0000;
      d    = {8'h44, 8'h33, 8'h22, 8'h11};

      // Reset held two cycles with all requests up.
      step();
      check_all("rst1", 4'b0000, 1'b0, 8'h00, 1'b0);
      step();
      check_all("rst2", 4'b0000, 1'b0, 8'h00, 1'b0);
      check_val("rst2.owner", 32'(owner), 32'd0);
      rst = 1'b0;

      // Fairness: 0,1,2,3,0 with one write each.
      step(); check_all("rr_g0", 4'b0001, 1'b0, 8'h00, 1'b1);
      step(); check_all("rr_w0", 4'b0000, 1'b1, 8'h11, 1'b0);
      step(); check_all("rr_g1", 4'b0010, 1'b0, 8'h11, 1'b1);
      check_val("rr_g1.owner", 32'(owner), 32'd1);
      step(); check_all("rr_w1", 4'b0000, 1'b1, 8'h22, 1'b0);
      step(); check_all("rr_g2", 4'b0100, 1'b0, 8'h22, 1'b1);
      step(); check_all("rr_w2", 4'b0000, 1'b1, 8'h33, 1'b0);
      step(); check_all("rr_g3", 4'b1000, 1'b0, 8'h33, 1'b1);
      step(); check_all("rr_w3", 4'b0000, 1'b1, 8'h44, 1'b0);
      step(); check_all("rr_g0b", 4'b0001, 1'b0, 8'h44, 1'b1);
      step(); check_all("rr_w0b", 4'b0000, 1'b1, 8'h11, 1'b0);
      req = 4'b0000;
      step(); check_all("idle", 4'b0000, 1'b0, 8'h11, 1'b0);
      check_val("idle.owner", 32'(owner), 32'd0);

      // Single write from requester 2.
      req = 4'b0100;
      d[2*8 +: 8] = 8'hA5;
      step(); check_all("sw_g", 4'b0100, 1'b0, 8'h11, 1'b1);
      step(); check_all("sw_w", 4'b0000, 1'b1, 8'hA5, 1'b0);
      req = 4'b0000;
      step(); check_all("sw_idle", 4'b0000, 1'b0, 8'hA5, 1'b0);

      // Locked burst from requester 1 saturating at four writes.
      req  = 4'b0010;
      lock = 4'b0010;
      d[1*8 +: 8] = 8'h10;
      step(); check_all("lb_g", 4'b0010, 1'b0, 8'hA5, 1'b1);
      step(); check_all("lb_w1", 4'b0010, 1'b1, 8'h10, 1'b1);
      d[1*8 +: 8] = 8'h11;
      step(); check_all("lb_w2", 4'b0010, 1'b1, 8'h11, 1'b1);
      d[1*8 +: 8] = 8'h12;
      step(); check_all("lb_w3", 4'b0010, 1'b1, 8'h12, 1'b1);
      d[1*8 +: 8] = 8'h13;
      req = 4'b1010;
      step(); check_all("lb_w4", 4'b0000, 1'b1, 8'h13, 1'b0);
      step(); check_all("lb_next", 4'b1000, 1'b0, 8'h13, 1'b1);
      check_val("lb_next.owner", 32'(owner), 32'd3);

      // Owner drop: requester 3 locked, withdraws after two writes.
      req  = 4'b1000;
      lock = 4'b1000;
      d[3*8 +: 8] = 8'h55;
      step(); check_all("od_w1", 4'b1000, 1'b1, 8'h55, 1'b1);
      d[3*8 +: 8] = 8'h66;
      step(); check_all("od_w2", 4'b1000, 1'b1, 8'h66, 1'b1);
      req = 4'b0000;
      d[3*8 +: 8] = 8'h99;
      step(); check_all("od_rel", 4'b0000, 1'b0, 8'h66, 1'b0);

      // Reset during the second write of a locked burst.
      req  = 4'b0001;
      lock = 4'b0001;
      d[0*8 +: 8] = 8'h77;
      step(); check_all("rm_g", 4'b0001, 1'b0, 8'h66, 1'b1);
      step(); check_all("rm_w1", 4'b0001, 1'b1, 8'h77, 1'b1);
      d[0*8 +: 8] = 8'h88;
      rst = 1'b1;
      step(); check_all("rm_rst", 4'b0000, 1'b0, 8'h00, 1'b0);
      rst = 1'b0;
      req = 4'b0011;
      step(); check_all("rm_g2", 4'b0001, 1'b0, 8'h00, 1'b1);
      check_val("rm_g2.owner", 32'(owner), 32'd0);
      step(); check_all("rm_w2", 4'b0001, 1'b1, 8'h88, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
